// File: rtl/fp_conv_pkg.sv
// Shared types for the fp-to-int converter: class encoding, exponent bias and
// the S1->S2 stage register layout (sized by FP_EXP_W/FP_MAN_W below).
package fp_conv_pkg;

  localparam int unsigned FP_EXP_W = 5;
  localparam int unsigned FP_MAN_W = 10;

  typedef enum logic [1:0] {
    ZERO,
    NORMAL,
    INF,
    NAN
  } fp_class_e;

  function automatic int unsigned bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  typedef struct packed {
    logic                     sign;
    fp_class_e                cls;
    logic signed [FP_EXP_W:0] e;
    logic [FP_MAN_W:0]        sig;
  } s1_t;

endpackage

// File: rtl/fp_sig_align.sv
// Combinational significand aligner: places sig at unbiased exponent e and
// reports the discarded fraction as guard/sticky, plus integer overflow.
module fp_sig_align #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10,
  parameter int unsigned INT_W = 16
) (
  input  logic                    [MAN_W:0] sig_i,
  input  logic signed             [EXP_W:0] e_i,
  output logic                    [INT_W-1:0] mag_o,
  output logic                              guard_o,
  output logic                              sticky_o,
  output logic                              ovf_o
);

  localparam int MAN_I = int'(MAN_W);
  localparam int INT_I = int'(INT_W);

  int                 e_int;
  logic [2*MAN_W:0]   ext;

  always_comb begin
    mag_o    = '0;
    guard_o  = 1'b0;
    sticky_o = 1'b0;
    ovf_o    = 1'b0;
    ext      = '0;
    e_int    = int'(e_i);
    if (e_int >= INT_I) begin
      ovf_o = 1'b1;
    end else if (e_int >= MAN_I) begin
      mag_o = INT_W'(sig_i) << (e_int - MAN_I);
    end else if (e_int >= 0) begin
      // Low MAN_W bits of ext collect everything shifted out.
      ext      = {sig_i, {MAN_W{1'b0}}} >> (MAN_I - e_int);
      mag_o    = INT_W'(ext[2*MAN_W:MAN_W]);
      guard_o  = ext[MAN_W-1];
      sticky_o = |ext[MAN_W-2:0];
    end else if (e_int == -1) begin
      guard_o  = 1'b1;
      sticky_o = |sig_i[MAN_W-1:0];
    end else begin
      sticky_o = 1'b1;
    end
  end

endmodule

// File: rtl/fp_to_int_conv.sv
// Two-stage fp -> signed integer converter with valid/ready on both sides.
// Rounding: FP_TO_INT_RNE_EN selects round-to-nearest-even, else truncation.
module fp_to_int_conv
  import fp_conv_pkg::*;
#(
  parameter int unsigned EXP_W = FP_EXP_W,
  parameter int unsigned MAN_W = FP_MAN_W,
  parameter int unsigned INT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [EXP_W+MAN_W:0]   in_fp_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [INT_W-1:0]       out_int_o,
  output logic                   out_invalid_o,
  output logic                   out_inexact_o
);

  if (EXP_W != FP_EXP_W || MAN_W != FP_MAN_W || INT_W <= MAN_W + 1) begin : g_bad_cfg
    $error("fp_to_int_conv: widths must match fp_conv_pkg and INT_W > MAN_W+1");
  end

  localparam logic [INT_W-1:0] MAX_INT = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MIN_INT = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W:0]   POS_LIM = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic [INT_W:0]   NEG_LIM = {2'b01, {(INT_W-1){1'b0}}};

  logic               sign_in;
  logic [EXP_W-1:0]   exp_in;
  logic [MAN_W-1:0]   man_in;

  s1_t                s1_d, s1_q;
  logic               s1_valid_d, s1_valid_q;
  logic               out_valid_d, out_valid_q;
  logic [INT_W-1:0]   out_int_d, out_int_q;
  logic               out_inv_d, out_inv_q;
  logic               out_inx_d, out_inx_q;

  logic               s1_adv, s2_adv;
  logic [INT_W-1:0]   mag;
  logic               guard, sticky, ovf, rnd_inc;
  logic [INT_W:0]     mag_r;
  logic [INT_W-1:0]   res;
  logic               res_inv, res_inx;

  assign sign_in = in_fp_i[EXP_W+MAN_W];
  assign exp_in  = in_fp_i[MAN_W +: EXP_W];
  assign man_in  = in_fp_i[MAN_W-1:0];

  assign s2_adv     = !out_valid_q || out_ready_i;
  assign s1_adv     = !s1_valid_q || s2_adv;
  assign in_ready_o = s1_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_adv) begin
      s1_valid_d = in_valid_i;
      if (in_valid_i) begin
        s1_d.sign = sign_in;
        s1_d.sig  = {1'b1, man_in};
        s1_d.e    = $signed({1'b0, exp_in}) - $signed((EXP_W+1)'(bias(EXP_W)));
        if (exp_in == '0)      s1_d.cls = ZERO;
        else if (exp_in == '1) s1_d.cls = (man_in == '0) ? INF : NAN;
        else                   s1_d.cls = NORMAL;
      end
    end
  end

  fp_sig_align #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W),
    .INT_W (INT_W)
  ) u_align (
    .sig_i    (s1_q.sig),
    .e_i      (s1_q.e),
    .mag_o    (mag),
    .guard_o  (guard),
    .sticky_o (sticky),
    .ovf_o    (ovf)
  );

`ifdef FP_TO_INT_RNE_EN
  assign rnd_inc = guard & (sticky | mag[0]);
`else
  assign rnd_inc = 1'b0;
`endif

  assign mag_r = {1'b0, mag} + (INT_W+1)'(rnd_inc);

  always_comb begin
    res     = '0;
    res_inv = 1'b0;
    res_inx = 1'b0;
    unique case (s1_q.cls)
      ZERO: ;
      NAN: begin
        res     = MAX_INT;
        res_inv = 1'b1;
      end
      INF: begin
        res     = s1_q.sign ? MIN_INT : MAX_INT;
        res_inv = 1'b1;
      end
      default: begin
        res_inx = guard | sticky;
        if (!s1_q.sign) begin
          if (ovf || mag_r > POS_LIM) begin
            res     = MAX_INT;
            res_inv = 1'b1;
          end else begin
            res = mag_r[INT_W-1:0];
          end
        end else begin
          if (ovf || mag_r > NEG_LIM) begin
            res     = MIN_INT;
            res_inv = 1'b1;
          end else begin
            res = INT_W'(-mag_r);
          end
        end
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_int_d   = out_int_q;
    out_inv_d   = out_inv_q;
    out_inx_d   = out_inx_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_int_d = res;
        out_inv_d = res_inv;
        out_inx_d = res_inx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_int_q   <= '0;
      out_inv_q   <= 1'b0;
      out_inx_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_int_q   <= out_int_d;
      out_inv_q   <= out_inv_d;
      out_inx_q   <= out_inx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    s1_q <= s1_d;
  end

  assign out_valid_o   = out_valid_q;
  assign out_int_o     = out_int_q;
  assign out_invalid_o = out_inv_q;
  assign out_inexact_o = out_inx_q;

endmodule

// File: tb/tb_fp_to_int_conv.sv
// Scoreboard bench for fp_to_int_conv (fp16 -> int16) with a real-valued
// reference model; honours FP_TO_INT_RNE_EN the same way as the design.
module tb_fp_to_int_conv;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [15:0] in_fp_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [15:0] out_int_o;
  logic        out_invalid_o;
  logic        out_inexact_o;

  typedef struct {
    logic [15:0] val;
    bit          inv;
    bit          inx;
    int          cyc;
    bit          lat;
    logic [15:0] fp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   bp_mode = 1'b0;
  bit   lat_mode = 1'b0;

  fp_to_int_conv #(
    .EXP_W (5),
    .MAN_W (10),
    .INT_W (16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_fp_i       (in_fp_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_int_o     (out_int_o),
    .out_invalid_o (out_invalid_o),
    .out_inexact_o (out_inexact_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: evaluate the fp16 value as a real, round, then clamp to int16.
  function automatic void model(input logic [15:0] f, output logic [15:0] val,
                                output bit inv, output bit inx);
    bit   s = f[15];
    int   ex = int'(f[14:10]);
    int   m = int'(f[9:0]);
    real  v;
    real  frac;
    int   t;
    int   r;
    inv = 1'b0;
    inx = 1'b0;
    if (ex == 31) begin
      inv = 1'b1;
      r = (m != 0) ? 32767 : (s ? -32768 : 32767);
    end else if (ex == 0) begin
      r = 0;
    end else begin
      v = 1.0 + real'(m) / 1024.0;
      if (ex > 15) repeat (ex - 15) v = v * 2.0;
      else         repeat (15 - ex) v = v / 2.0;
      t    = $rtoi(v);
      frac = v - real'(t);
      inx  = (frac != 0.0);
`ifdef FP_TO_INT_RNE_EN
      if (frac > 0.5 || (frac == 0.5 && (t % 2) == 1)) t = t + 1;
`endif
      r = s ? -t : t;
      if (r > 32767)  begin r = 32767;  inv = 1'b1; end
      if (r < -32768) begin r = -32768; inv = 1'b1; end
    end
    val = r[15:0];
  endfunction

  function automatic logic [15:0] rand_fp();
    logic [15:0] f;
    f = 16'($urandom);
    if ($urandom_range(0, 3) != 0) f[14:10] = 5'($urandom_range(10, 31));
    return f;
  endfunction

  task automatic send(input logic [15:0] f);
    exp_t e;
    bit   done = 1'b0;
    in_valid_i = 1'b1;
    in_fp_i    = f;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready_o) begin
        model(f, e.val, e.inv, e.inx);
        e.cyc = cyc;
        e.lat = lat_mode;
        e.fp  = f;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout fp=%h in_ready stayed 0, required acceptance", f);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required 0", sb.size());
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_mode) out_ready_i = 1'($urandom_range(0, 1));
  end

  // Monitor: handshake rule, stall stability, in-order result comparison.
  initial begin
    int          occ = 0;
    bit          stall = 1'b0;
    logic [15:0] p_int = '0;
    bit          p_inv = 1'b0;
    bit          p_inx = 1'b0;
    bit          acc, cons;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        occ   = 0;
        stall = 1'b0;
      end else begin
        acc  = in_valid_i && in_ready_o;
        cons = out_valid_o && out_ready_i;
        checks++;
        if (in_ready_o !== !(occ == 2 && !out_ready_i)) begin
          errors++;
          $display("FAIL in_ready occ=%0d out_ready=%b got %b required %b",
                   occ, out_ready_i, in_ready_o, !(occ == 2 && !out_ready_i));
        end
        if (stall) begin
          checks++;
          if (out_valid_o !== 1'b1 || out_int_o !== p_int ||
              out_invalid_o !== p_inv || out_inexact_o !== p_inx) begin
            errors++;
            $display("FAIL stall_hold got v=%b %h/%b/%b required v=1 %h/%b/%b",
                     out_valid_o, out_int_o, out_invalid_o, out_inexact_o, p_int, p_inv, p_inx);
          end
        end
        if (cons) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL spurious_output got %h required no output", out_int_o);
          end else begin
            e = sb.pop_front();
            if (out_int_o !== e.val || out_invalid_o !== e.inv || out_inexact_o !== e.inx) begin
              errors++;
              $display("FAIL result fp=%h got %h inv=%b inx=%b required %h inv=%b inx=%b",
                       e.fp, out_int_o, out_invalid_o, out_inexact_o, e.val, e.inv, e.inx);
            end
            if (e.lat) begin
              checks++;
              if (cyc - e.cyc != 2) begin
                errors++;
                $display("FAIL latency fp=%h got %0d cycles required 2", e.fp, cyc - e.cyc);
              end
            end
          end
        end
        stall = out_valid_o && !out_ready_i;
        p_int = out_int_o;
        p_inv = out_invalid_o;
        p_inx = out_inexact_o;
        occ   = occ + int'(acc) - int'(cons);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] dir [16] = '{16'h3C00, 16'h4100, 16'h4300, 16'hBE00,
                              16'h3A00, 16'h3800, 16'hF800, 16'h7800,
                              16'h7BFF, 16'h7C00, 16'hFC00, 16'h7E00,
                              16'h0001, 16'h0000, 16'h3400, 16'hC700};

    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    checks++;
    if (out_valid_o !== 1'b0 || out_int_o !== 16'h0 || out_invalid_o !== 1'b0 ||
        out_inexact_o !== 1'b0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got v=%b int=%h inv=%b inx=%b rdy=%b required 0/0000/0/0/1",
               out_valid_o, out_int_o, out_invalid_o, out_inexact_o, in_ready_o);
    end

    foreach (dir[i]) send(dir[i]);
    drain();
    for (int i = 0; i < 40; i++) send(rand_fp());
    drain();

    bp_mode = 1'b1;
    for (int i = 0; i < 8; i++) send(dir[i + 4]);
    for (int i = 0; i < 24; i++) send(rand_fp());
    drain();
    bp_mode = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk); #1;

    lat_mode = 1'b1;
    for (int i = 0; i < 16; i++) send(rand_fp());
    lat_mode = 1'b0;
    drain();

    out_ready_i = 1'b0;
    send(16'h4300);
    send(16'hBE00);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    sb.delete();
    checks++;
    if (out_valid_o !== 1'b0 || out_int_o !== 16'h0) begin
      errors++;
      $display("FAIL midstream_reset got v=%b int=%h required v=0 int=0000",
               out_valid_o, out_int_o);
    end
    out_ready_i = 1'b1;
    send(16'h4100);
    drain();

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
